spike_aer_encoder: RTL

//  Consumer end of the neuron-population spike raster. Captures one 128-bit population

---
 rtl/aer_pkg.sv | 34 +++
 rtl/aer_if.sv | 30 +++
 rtl/aer_prio_enc.sv | 25 ++
 rtl/spike_aer_encoder.sv | 105 ++++++++++
 4 files changed

// File: rtl/aer_pkg.sv
// Shared AER definitions: widths, FSM state encoding and host word layout.
// Imported by the encoder, its priority encoder and the stream interface.
package aer_pkg;

   localparam int AER_N_NEURONS = 128;
   localparam int AER_ADDR_W    = 7;
   localparam int AER_TS_W      = 16;
   localparam int AER_OVF_W     = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } aer_state_t;

   // Host-side packed event word {ts, last, addr}.
   typedef struct packed {
      logic [AER_TS_W-1:0]   ts;
      logic                  last;
      logic [AER_ADDR_W-1:0] addr;
   } aer_word_t;

   function automatic aer_word_t aer_pack(
      input logic [AER_TS_W-1:0]   ts,
      input logic                  last,
      input logic [AER_ADDR_W-1:0] addr
   );
      aer_word_t w;
      w.ts   = ts;
      w.last = last;
      w.addr = addr;
      return w;
   endfunction

endpackage

// File: rtl/aer_if.sv
// AER event stream: valid/ready handshake carrying address, last flag, timestamp.
// master drives valid/addr/last/ts and samples ready; slave is the reverse.
interface aer_if
   import aer_pkg::*;
#(
   parameter int ADDR_W = AER_ADDR_W,
   parameter int TS_W   = AER_TS_W
);
   logic              aer_valid;
   logic              aer_ready;
   logic [ADDR_W-1:0] aer_addr;
   logic              aer_last;
   logic [TS_W-1:0]   aer_ts;

   modport master (
      output aer_valid,
      output aer_addr,
      output aer_last,
      output aer_ts,
      input  aer_ready
   );

   modport slave (
      input  aer_valid,
      input  aer_addr,
      input  aer_last,
      input  aer_ts,
      output aer_ready
   );
endinterface

// File: rtl/aer_prio_enc.sv
// Combinational lowest-set-bit encoder.
// Ports: vec in; idx (index of lowest set bit), any (vec != 0), onehot_lsb out.
module aer_prio_enc #(
   parameter int N = 128,
   parameter int W = 7
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any,
   output logic [N-1:0] onehot_lsb
);

   assign any        = |vec;
   // Two's-complement trick isolates the lowest set bit.
   assign onehot_lsb = vec & (~vec + N'(1));

   // Scan high to low so the lowest set bit wins.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx = W'(i);
      end
   end

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike raster to AER serialiser: captures a population frame per strobe, emits
// firing neuron indices lowest first. Ports: clk, reset (async, active-high),
// pop_in, frame_strobe, aer (aer_if.master), busy, ovf_cnt. Optional macro:
// AER_TIMESTAMP_EN builds the frame timestamp path; otherwise aer_ts is 0.
module spike_aer_encoder
   import aer_pkg::*;
#(
   parameter int N_NEURONS = AER_N_NEURONS,
   parameter int ADDR_W    = AER_ADDR_W,
   parameter int TS_W      = AER_TS_W,
   parameter int OVF_W     = AER_OVF_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_NEURONS-1:0] pop_in,
   input  logic                 frame_strobe,
   aer_if.master                aer,
   output logic                 busy,
   output logic [OVF_W-1:0]     ovf_cnt
);

   aer_state_t           state, state_n;
   logic [N_NEURONS-1:0] pending, pending_n;
   logic [N_NEURONS-1:0] lsb_oh;
   logic [ADDR_W-1:0]    lsb_idx;
   logic                 any;
   logic                 send;
   logic                 last;
   logic                 hs;
   logic                 cap;
   logic                 drop;

   aer_prio_enc #(
      .N (N_NEURONS),
      .W (ADDR_W)
   ) u_enc (
      .vec        (pending),
      .idx        (lsb_idx),
      .any        (any),
      .onehot_lsb (lsb_oh)
   );

   assign send = (state == SEND);
   assign last = ((pending & (pending - N_NEURONS'(1))) == '0);
   assign hs   = aer.aer_valid & aer.aer_ready;
   // A new frame may only land when idle or exactly as the old one finishes.
   assign cap  = frame_strobe & (~send | (hs & last));
   assign drop = frame_strobe & ~cap;

   assign aer.aer_valid = send & any;
   assign aer.aer_addr  = send ? lsb_idx : '0;
   assign aer.aer_last  = send & last;
   assign busy          = send;

   always_comb begin
      state_n   = state;
      pending_n = pending;
      if (hs) begin
         pending_n = pending & ~lsb_oh;
         if (last) state_n = IDLE;
      end
      if (cap) begin
         pending_n = pop_in;
         state_n   = (pop_in != '0) ? SEND : IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         pending <= '0;
      end else begin
         state   <= state_n;
         pending <= pending_n;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_cnt <= '0;
      end else if (drop && (ovf_cnt != '1)) begin
         ovf_cnt <= ovf_cnt + OVF_W'(1);
      end
   end

`ifdef AER_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;
   logic [TS_W-1:0] frame_ts;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_cnt   <= '0;
         frame_ts <= '0;
      end else begin
         if (frame_strobe) ts_cnt <= ts_cnt + TS_W'(1);
         if (cap) frame_ts <= ts_cnt;
      end
   end

   assign aer.aer_ts = send ? frame_ts : '0;
`else
   assign aer.aer_ts = '0;
`endif

endmodule
